// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Default widths, FSM encodings and queue-entry helpers.
package instruction_fetch_pkg;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 16;
  localparam int DEPTH_DEF = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Prefetch FIFO holding {fetch address, instruction word} pairs.
// Synchronous clear wins over push/pop; push and pop may coincide.
module instruction_fetch_queue
  import instruction_fetch_pkg::*;
#(
  parameter int W     = AW_DEF + IW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until count says so.
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives PC enable, reads instruction memory and
// queues {pc, instr} for decode over a valid/ready handshake.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int IW    = IW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  output logic          pc_enable,
  input  logic          flush,
  input  logic          halt,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [IW-1:0] mem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc
);

  localparam int CW = cnt_w(DEPTH);
  localparam int EW = AW + IW;

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic          inflight;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [EW-1:0] head;
  logic          pop;
  logic          push;
  logic          room;
  logic          issue;
  logic [CW:0]   credit;

  assign instr_valid = !empty && !flush;
  assign pop         = instr_valid && instr_ready;
  assign push        = inflight && !flush;

  // Occupancy the queue would reach once the pending read lands.
  assign credit = {1'b0, count}
                + (CW+1)'(inflight)
                - (CW+1)'(pop);
  assign room   = !full || pop;

  assign issue = (state == S_RUN)
              && !halt
              && !flush
              && room
              && (credit < (CW+1)'(DEPTH));

  assign pc_enable = issue;
  assign mem_rd_en = issue;
  assign mem_addr  = issue ? pc_in : '0;

  assign instr    = empty ? '0 : head[IW-1:0];
  assign instr_pc = empty ? '0 : head[EW-1:IW];

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  state_nx = S_RUN;
      S_RUN:   if (halt) state_nx = S_HALT;
      S_HALT:  if (!halt) state_nx = S_RUN;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      inflight <= 1'b0;
      addr_q   <= '0;
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (issue)
        addr_q <= pc_in;
    end
  end

  instruction_fetch_queue #(
    .W     (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({addr_q, mem_rdata}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule
